// File: rtl/booth_mul_arbiter.sv
// Round-robin sequencer sharing one booth_multiplier among NUM_REQ requesters.
// One transaction is in flight at a time, and a watchdog bounds the wait for completion.
module booth_mul_arbiter #(
    parameter int MUL_WIDTH = 4,
    parameter int NUM_REQ   = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_i,
    input  logic [NUM_REQ-1:0]           req_sign_i,
    input  logic [NUM_REQ*MUL_WIDTH-1:0] req_a_i,
    input  logic [NUM_REQ*MUL_WIDTH-1:0] req_b_i,
    output logic [NUM_REQ-1:0]           gnt_o,
    output logic [NUM_REQ-1:0]           rsp_valid_o,
    output logic [2*MUL_WIDTH-1:0]       rsp_data_o,
    output logic                         rsp_err_o,
    output logic                         mul_start_o,
    output logic                         mul_sign_o,
    output logic [MUL_WIDTH-1:0]         mul_a_o,
    output logic [MUL_WIDTH-1:0]         mul_b_o,
    input  logic [2*MUL_WIDTH-1:0]       mul_y_i,
    input  logic                         mul_ready_i
);

    localparam int IDXW = $clog2(NUM_REQ);
    localparam int CNTW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t                 state_q, state_d;
    logic [IDXW-1:0]        ptr_q, ptr_d;
    logic [IDXW-1:0]        idx_q, idx_d;
    logic [CNTW-1:0]        cnt_q, cnt_d;
    logic                   ready_q;
    logic [NUM_REQ-1:0]     gnt_q, gnt_d;
    logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
    logic [2*MUL_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                   rsp_err_q, rsp_err_d;
    logic                   mul_start_q, mul_start_d;
    logic                   mul_sign_q, mul_sign_d;
    logic [MUL_WIDTH-1:0]   mul_a_q, mul_a_d;
    logic [MUL_WIDTH-1:0]   mul_b_q, mul_b_d;

    logic                   anyReq;
    logic [IDXW-1:0]        selIdx;
    logic [IDXW-1:0]        cand;
    logic                   selSign;
    logic [MUL_WIDTH-1:0]   selA;
    logic [MUL_WIDTH-1:0]   selB;
    logic                   mulDone;

    // Only a fresh rising edge of ready counts, so a level left high by the
    // previous operation is never mistaken for completion.
    assign mulDone = mul_ready_i & ~ready_q;

    always_comb begin
        anyReq = 1'b0;
        selIdx = '0;
        cand   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IDXW'((int'(ptr_q) + i) % NUM_REQ);
            if (!anyReq && req_i[cand]) begin
                anyReq = 1'b1;
                selIdx = cand;
            end
        end
    end

    always_comb begin
        selSign = 1'b0;
        selA    = '0;
        selB    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (selIdx == IDXW'(i)) begin
                selSign = req_sign_i[i];
                selA    = req_a_i[i*MUL_WIDTH +: MUL_WIDTH];
                selB    = req_b_i[i*MUL_WIDTH +: MUL_WIDTH];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        gnt_d       = '0;
        mul_start_d = 1'b0;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        mul_sign_d  = mul_sign_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        unique case (state_q)
            ST_IDLE: begin
                if (anyReq) begin
                    idx_d         = selIdx;
                    mul_sign_d    = selSign;
                    mul_a_d       = selA;
                    mul_b_d       = selB;
                    gnt_d[selIdx] = 1'b1;
                    mul_start_d   = 1'b1;
                    cnt_d         = '0;
                    state_d       = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // Completion takes priority over a watchdog expiry in the same cycle.
                if (mulDone) begin
                    rsp_data_d         = mul_y_i;
                    rsp_err_d          = 1'b0;
                    rsp_valid_d[idx_q] = 1'b1;
                    state_d            = ST_RESP;
                end else if (cnt_q == CNTW'(TIMEOUT)) begin
                    rsp_data_d         = '0;
                    rsp_err_d          = 1'b1;
                    rsp_valid_d[idx_q] = 1'b1;
                    state_d            = ST_RESP;
                end
            end
            ST_RESP: begin
                ptr_d   = (idx_q == IDXW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            mul_start_q <= 1'b0;
            mul_sign_q  <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            ready_q     <= mul_ready_i;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            mul_start_q <= mul_start_d;
            mul_sign_q  <= mul_sign_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;
    assign mul_start_o = mul_start_q;
    assign mul_sign_o  = mul_sign_q;
    assign mul_a_o     = mul_a_q;
    assign mul_b_o     = mul_b_q;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Self-checking bench for booth_mul_arbiter: a behavioural multiplier with adjustable
// latency, stale-ready and dead modes, and a round-robin/product reference model.
module tb_booth_mul_arbiter;

    localparam int MW = 4;
    localparam int NR = 4;
    localparam int TO = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req, reqSign;
    logic [NR*MW-1:0] reqA, reqB;
    logic [NR-1:0]   gnt, rspValid;
    logic [2*MW-1:0] rspData;
    logic            rspErr, mulStart, mulSign;
    logic [MW-1:0]   mulA, mulB;
    logic [2*MW-1:0] mulY;
    logic            mulReady;

    int vectors     = 0;
    int miscompares = 0;

    logic [MW-1:0] opA [NR];
    logic [MW-1:0] opB [NR];
    logic          opS [NR];
    logic [NR-1:0] reqMask;
    int            refPtr     = 0;
    int            mulLatency = 3;
    int            staleHold  = 0;
    bit            neverReady = 1'b0;

    booth_mul_arbiter #(.MUL_WIDTH(MW), .NUM_REQ(NR), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req),
        .req_sign_i (reqSign),
        .req_a_i    (reqA),
        .req_b_i    (reqB),
        .gnt_o      (gnt),
        .rsp_valid_o(rspValid),
        .rsp_data_o (rspData),
        .rsp_err_o  (rspErr),
        .mul_start_o(mulStart),
        .mul_sign_o (mulSign),
        .mul_a_o    (mulA),
        .mul_b_o    (mulB),
        .mul_y_i    (mulY),
        .mul_ready_i(mulReady)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] refProd(input logic [3:0] a, input logic [3:0] b, input logic s);
        int x, y, p;
        x = s ? int'($signed(a)) : int'(a);
        y = s ? int'($signed(b)) : int'(b);
        p = x * y;
        return p[7:0];
    endfunction

    function automatic int refPick(input logic [NR-1:0] m, input int p);
        for (int i = 0; i < NR; i++)
            if (m[(p + i) % NR]) return (p + i) % NR;
        return 0;
    endfunction

    function automatic logic [31:0] allOutputs();
        return 32'({gnt, rspValid, rspData, rspErr, mulStart, mulSign, mulA, mulB});
    endfunction

    // Multiplier stand-in: ready is a level that stays high after completion and
    // drops (optionally staleHold cycles late) once a new start is seen.
    logic          mBusy;
    int            mCnt;
    logic [MW-1:0] mA, mB;
    logic          mS;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mulReady <= 1'b0;
            mulY     <= '0;
            mBusy    <= 1'b0;
            mCnt     <= 0;
        end else if (mulStart) begin
            mBusy <= 1'b1;
            mCnt  <= 0;
            mA    <= mulA;
            mB    <= mulB;
            mS    <= mulSign;
            if (staleHold == 0) mulReady <= 1'b0;
        end else if (mBusy) begin
            mCnt <= mCnt + 1;
            if (neverReady) begin
                mulReady <= 1'b0;
                mBusy    <= 1'b0;
            end else if (mCnt + 1 < mulLatency) begin
                if (mCnt + 1 >= staleHold) mulReady <= 1'b0;
            end else begin
                mulReady <= 1'b1;
                mulY     <= refProd(mA, mB, mS);
                mBusy    <= 1'b0;
            end
        end
    end

    task automatic applyStimulus();
        req = reqMask;
        for (int i = 0; i < NR; i++) begin
            reqSign[i]         = opS[i];
            reqA[i*MW +: MW]   = opA[i];
            reqB[i*MW +: MW]   = opB[i];
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic randomizeOps(input int i);
        opA[i] = 4'($urandom_range(0, 15));
        opB[i] = 4'($urandom_range(0, 15));
        opS[i] = 1'($urandom_range(0, 1));
    endtask

    // One full grant/response transaction against the reference model.
    task automatic doTxn(input string tag, input int lat, input bit expTimeout, input bit keepReq);
        int            k, cyc, extra;
        logic [7:0]    expData;
        logic [MW-1:0] ea, eb;
        logic          es;
        mulLatency = lat;
        neverReady = expTimeout;
        k   = refPick(reqMask, refPtr);
        cyc = 0;
        while (gnt === '0 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput($sformatf("%s gnt", tag), 32'(gnt), 32'(1) << k);
        if (gnt === '0) return;
        checkOutput($sformatf("%s start", tag), 32'({mulStart, rspValid}), 32'({1'b1, 4'b0000}));
        checkOutput($sformatf("%s operands", tag), 32'({mulSign, mulA, mulB}), 32'({opS[k], opA[k], opB[k]}));
        ea = opA[k];
        eb = opB[k];
        es = opS[k];
        expData = expTimeout ? 8'h00 : refProd(ea, eb, es);
        if (!keepReq) reqMask[k] = 1'b0;
        randomizeOps(k);
        applyStimulus();
        cyc   = 0;
        extra = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (gnt !== '0 || mulStart !== 1'b0) extra++;
        end while (rspValid === '0 && cyc < 200);
        checkOutput($sformatf("%s latency", tag), 32'(cyc), 32'(expTimeout ? TO + 1 : lat + 2));
        checkOutput($sformatf("%s rsp_valid", tag), 32'(rspValid), 32'(1) << k);
        checkOutput($sformatf("%s rsp_data", tag), 32'(rspData), 32'(expData));
        checkOutput($sformatf("%s rsp_err", tag), 32'(rspErr), 32'(expTimeout));
        checkOutput($sformatf("%s held operands", tag), 32'({mulSign, mulA, mulB}), 32'({es, ea, eb}));
        checkOutput($sformatf("%s stray pulses", tag), 32'(extra), 32'(0));
        refPtr = (k + 1) % NR;
        @(negedge clk);
        checkOutput($sformatf("%s after resp", tag), 32'({gnt, rspValid, rspData, rspErr}),
                    32'({8'h00, expData, expTimeout}));
    endtask

    initial begin
        int cyc, seen;
        for (int i = 0; i < NR; i++) begin
            opA[i] = '0;
            opB[i] = '0;
            opS[i] = 1'b0;
        end
        reqMask = '0;
        applyStimulus();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset outputs", allOutputs(), 32'(0));
        rst = 1'b0;

        opA[0] = 4'h9; opB[0] = 4'hE; opS[0] = 1'b1;
        reqMask = 4'b0001;
        applyStimulus();
        doTxn("signed", 3, 1'b0, 1'b0);

        opA[2] = 4'hF; opB[2] = 4'h2; opS[2] = 1'b0;
        reqMask = 4'b0100;
        applyStimulus();
        doTxn("unsigned", 4, 1'b0, 1'b0);

        rst = 1'b1;
        opA[0] = 4'h2; opB[0] = 4'h5; opS[0] = 1'b0;
        opA[1] = 4'h3; opB[1] = 4'hD; opS[1] = 1'b1;
        opA[2] = 4'h7; opB[2] = 4'h9; opS[2] = 1'b0;
        opA[3] = 4'hC; opB[3] = 4'h4; opS[3] = 1'b1;
        reqMask = 4'b1111;
        applyStimulus();
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        refPtr = 0;
        for (int n = 0; n < 5; n++)
            doTxn($sformatf("rr%0d", n), int'($urandom_range(1, 6)), 1'b0, 1'b1);

        for (int n = 0; n < 16; n++) begin
            reqMask = 4'($urandom_range(1, 15));
            for (int i = 0; i < NR; i++) randomizeOps(i);
            applyStimulus();
            doTxn($sformatf("rand%0d", n), int'($urandom_range(1, 8)), 1'b0, 1'($urandom_range(0, 1)));
        end

        reqMask = 4'($urandom_range(1, 15));
        applyStimulus();
        doTxn("timeout", 3, 1'b1, 1'b0);
        reqMask = 4'($urandom_range(1, 15));
        applyStimulus();
        doTxn("post-timeout", 2, 1'b0, 1'b0);

        staleHold = 3;
        reqMask = 4'($urandom_range(1, 15));
        applyStimulus();
        doTxn("stale ready", 6, 1'b0, 1'b0);
        staleHold = 0;

        opA[1] = 4'h5; opB[1] = 4'h3; opS[1] = 1'b0;
        reqMask = 4'b0010;
        applyStimulus();
        doTxn("prep", 2, 1'b0, 1'b0);
        opA[3] = 4'h6; opB[3] = 4'h7; opS[3] = 1'b1;
        reqMask = 4'b1010;
        applyStimulus();
        mulLatency = 8;
        cyc = 0;
        while (gnt === '0 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("rstwait gnt", 32'(gnt), 32'(1) << refPick(reqMask, refPtr));
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("rst mid-wait outputs", allOutputs(), 32'(0));
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (rspValid !== '0) seen++;
        end
        rst    = 1'b0;
        refPtr = 0;
        checkOutput("rst no rsp", 32'(seen), 32'(0));
        doTxn("after rst", 3, 1'b0, 1'b0);
        doTxn("after rst 2", 3, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/booth_mul_arbiter.md
# booth_mul_arbiter

Round-robin arbiter and sequencer that shares one `booth_multiplier` instance among `NUM_REQ` requesters. It accepts operand/sign requests, issues a single-cycle start to the multiplier, and waits for completion. It then returns the product, with an error flag on watchdog timeout, to the requester that was granted. It sits between the requesting datapath blocks and the multiplier's `start/sign/data_in1/data_in2/data_out/ready` ports.

## Interface
- `MUL_WIDTH`, 4, operand width; product width is 2*MUL_WIDTH.
- `NUM_REQ`, 4, number of requesters (2..16).
- `TIMEOUT`, 64, maximum cycles to wait for multiplier completion (>= 2).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  NUM_REQ  per-requester request level.
- `req_sign`  in  NUM_REQ  per-requester signed (1) / unsigned (0) select.
- `req_a`  in  NUM_REQ*MUL_WIDTH  packed operand A; requester i at bits [i*MUL_WIDTH +: MUL_WIDTH].
- `req_b`  in  NUM_REQ*MUL_WIDTH  packed operand B, same packing.
- `gnt`  out  NUM_REQ  one-hot, one-cycle accept pulse.
- `rsp_valid`  out  NUM_REQ  one-hot, one-cycle result pulse.
- `rsp_data`  out  2*MUL_WIDTH  product, valid while any `rsp_valid` bit is high.
- `rsp_err`  out  1  timeout flag, qualified by `rsp_valid`.
- `mul_start`  out  1  start pulse to multiplier.
- `mul_sign`  out  1  sign to multiplier.
- `mul_a`, `mul_b`  out  MUL_WIDTH  operands to multiplier.
- `mul_y`  in  2*MUL_WIDTH  multiplier product.
- `mul_ready`  in  1  multiplier done level.

## Operation
- All outputs are registered. On reset, every output is 0, the state is IDLE, the round-robin pointer is 0, the timeout counter is 0, and `ready_q` is 0.
- `ready_q` registers `mul_ready` every cycle. Completion is `mul_ready & ~ready_q`, a rising edge. A level that is already high at start is never treated as done.
- IDLE state:
  - If any `req` bit is set, select the first set bit searching upward from the pointer, with wrap-around. Call it index k.
  - Latch k, `req_sign[k]`, `req_a[k]` and `req_b[k]` into `mul_sign/mul_a/mul_b`.
  - Set `gnt[k]`=1 and `mul_start`=1, clear the counter, and go to WAIT.
  - With no request, stay in IDLE.
- WAIT state:
  - `gnt` and `mul_start` return to 0 after one cycle.
  - `mul_sign/mul_a/mul_b` hold until the next grant.
  - The counter increments each cycle.
  - On completion: `rsp_data`<=`mul_y`, `rsp_err`<=0, go to RESP.
  - Otherwise, when the counter reaches TIMEOUT: `rsp_data`<=0, `rsp_err`<=1, go to RESP.
  - If completion and timeout occur in the same cycle, completion wins.
- RESP state:
  - `rsp_valid[k]`=1 for exactly one cycle. `rsp_data/rsp_err` hold until the next RESP.
  - The pointer becomes k+1 mod NUM_REQ. Go to IDLE.
- Requester protocol:
  - Hold `req` and operands stable until `gnt` is seen.
  - Operands may change in the cycle after `gnt`.
  - `req` may stay high to request again; the new request is arbitrated only after that requester's RESP.
- Dropping `req` before `gnt` withdraws the request with no side effect.
- Reset mid-operation aborts: no `rsp_valid` is emitted for the in-flight request. The multiplier must be reset by the same event at the top level (`rst_n` = ~`rst`).

## Timing
- Request sampled at edge n: `gnt` and `mul_start` are high in cycle n+1.
- Multiplier ready rising edge sampled at edge m: `rsp_valid` is high in cycle m+1.
- Minimum request-to-request turnaround for one requester is 3 cycles plus multiplier latency. IDLE is re-entered for one cycle between transactions.
- Timeout: with no completion, `rsp_valid` asserts TIMEOUT+1 cycles after `mul_start`.
- At most one transaction is in flight. `gnt`, `mul_start` and `rsp_valid` are never simultaneously high.

## Test plan
- Single request, signed: after reset, `req[0]`=1 with a=-7, b=-2, sign=1. Expect `gnt`=4'b0001 in the next cycle and one `mul_start` pulse, then `rsp_valid`=4'b0001 with `rsp_data`=8'h0E and `rsp_err`=0.
- Unsigned: `req[2]` with a=4'hF, b=4'h2, sign=0. Expect `rsp_data`=8'h1E, delivered on `rsp_valid[2]` only.
- Round-robin: all four `req` held high from reset with distinct operands. Expect grant order 0,1,2,3,0, and each response matches its own operands (e.g. 3*-3=8'hF7 signed).
- Timeout: a multiplier model holds `mul_ready`=0. Expect `rsp_valid` exactly 65 cycles after `mul_start` with `rsp_err`=1 and `rsp_data`=0, then the next grant proceeds normally.
- Stale ready: `mul_ready` is already 1 at `mul_start` and falls before the real rising edge. Expect no response until that rising edge.
- Reset in WAIT: assert `rst` mid-multiply. Expect all outputs 0 immediately and no `rsp_valid`. After release, the pending `req[3]`+`req[1]` grants index 1 first (pointer reset to 0).
